// File: rtl/serial_comp_pkg.sv
// Shared types and helpers for the serial two's-complement scheduler.
package serial_comp_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ  = 4;
  localparam int MAX_NREQ  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [MAX_NREQ-1:0] onehot(input int unsigned idx);
    onehot = MAX_NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/serial_comp_sched_rr_arbiter.sv
// Round-robin arbiter: combinational winner from req and a rotating priority
// pointer; the pointer moves past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            grant_en,
  output logic [IDW-1:0]  winner,
  output logic            valid
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] idx;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(ptr_q) + i) % NREQ);
      if (!valid && req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_en && valid) begin
      ptr_d = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/serial_comp_sched.sv
// Shares one LSB-first serial two's-complement engine among NREQ requesters.
// Optional most-negative detection on ovf is built when SERIAL_COMP_OVF_EN is defined.
module serial_comp_sched
  import serial_comp_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREQ  = DEF_NREQ,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] num,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [WIDTH-1:0]      comp_reg,
  output logic                  carry,
  output logic                  ovf
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] comp_q, comp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   win_q, win_d;
  logic [IDW-1:0]   done_id_q, done_id_d;
  logic             seen_q, seen_d;
  logic             carry_q, carry_d;
`ifdef SERIAL_COMP_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             b, out_bit;
  logic [IDW-1:0]   arb_winner;
  logic             arb_valid;
  logic             arb_take;

  // Arbiter only advances while idle, so req changes mid-operation are ignored.
  assign arb_take = (state_q == IDLE);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .grant_en(arb_take),
    .winner  (arb_winner),
    .valid   (arb_valid)
  );

  // Bits pass unchanged up to and including the first 1; all later bits invert.
  assign b       = sreg_q[0];
  assign out_bit = seen_q ? ~b : b;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sreg_d    = sreg_q;
    res_d     = res_q;
    comp_d    = comp_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    done_id_d = done_id_q;
    seen_d    = seen_q;
    carry_d   = carry_q;
`ifdef SERIAL_COMP_OVF_EN
    ovf_d     = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d   = NREQ'(onehot(32'(arb_winner)));
          win_d   = arb_winner;
          sreg_d  = num[int'(arb_winner)*WIDTH +: WIDTH];
          cnt_d   = '0;
          seen_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        seen_d = seen_q | b;
        res_d  = {out_bit, res_q[WIDTH-1:1]};
        sreg_d = sreg_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          comp_d    = {out_bit, res_q[WIDTH-1:1]};
          carry_d   = ~(seen_q | b);
          done_id_d = win_q;
          cnt_d     = '0;
`ifdef SERIAL_COMP_OVF_EN
          // Most-negative: all lower bits zero and only the MSB set.
          ovf_d     = ~seen_q & b;
`endif
          state_d   = DONE;
        end
      end
      DONE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset along with control so an aborted
  // operation leaves no stale operand or partial result behind.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sreg_q    <= '0;
      res_q     <= '0;
      comp_q    <= '0;
      cnt_q     <= '0;
      win_q     <= '0;
      done_id_q <= '0;
      seen_q    <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sreg_q    <= sreg_d;
      res_q     <= res_d;
      comp_q    <= comp_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      done_id_q <= done_id_d;
      seen_q    <= seen_d;
      carry_q   <= carry_d;
    end
  end

`ifdef SERIAL_COMP_OVF_EN
  always_ff @(posedge clk) begin
    if (!rst) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign gnt      = gnt_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign done_id  = done_id_q;
  assign comp_reg = comp_q;
  assign carry    = carry_q;

endmodule

// File: tb/tb_serial_comp_sched.sv
// Directed bench for serial_comp_sched with an expected-result queue.
module tb_serial_comp_sched;

  localparam int W = 4;
  localparam int N = 4;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] comp;
    logic         carry;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N*W-1:0] num;
  logic [N-1:0] gnt;
  logic         busy;
  logic         done;
  logic [1:0]   done_id;
  logic [W-1:0] comp_reg;
  logic         carry;
  logic         ovf;

  int   total;
  int   bad;
  int   lat;
  exp_t sb[$];

  serial_comp_sched #(.WIDTH(W), .NREQ(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .num     (num),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .comp_reg(comp_reg),
    .carry   (carry),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: negate modulo 2^W, carry when operand is zero.
  function automatic exp_t model(input int id, input logic [W-1:0] op);
    exp_t e;
    e.id    = 2'(id);
    e.comp  = W'(0) - op;
    e.carry = (op == '0);
`ifdef SERIAL_COMP_OVF_EN
    e.ovf   = (op == {1'b1, {(W-1){1'b0}}});
`else
    e.ovf   = 1'b0;
`endif
    return e;
  endfunction

  task automatic request(input int id, input logic [W-1:0] op);
    num[id*W +: W] = op;
    req[id]        = 1'b1;
    sb.push_back(model(id, op));
  endtask

  // Waits (bounded) on negedges for done; returns the cycle count.
  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cycles = i;
        break;
      end
    end
    if (cycles == 0) check({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic expect_done(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_unexpected_done"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_id"},    32'(done_id),  32'(e.id));
    check({tag, "_gnt"},   32'(gnt),      32'(1 << e.id));
    check({tag, "_comp"},  32'(comp_reg), 32'(e.comp));
    check({tag, "_carry"}, 32'(carry),    32'(e.carry));
    check({tag, "_ovf"},   32'(ovf),      32'(e.ovf));
    req[e.id] = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_gnt"},  32'(gnt),  32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    req   = '1;
    num   = '0;

    // Reset held with all requests pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_gnt",   32'(gnt),      32'd0);
      check("rst_done",  32'(done),     32'd0);
      check("rst_comp",  32'(comp_reg), 32'd0);
      check("rst_carry", 32'(carry),    32'd0);
    end
    check("rst_busy", 32'(busy),    32'd0);
    check("rst_id",   32'(done_id), 32'd0);
    check("rst_ovf",  32'(ovf),     32'd0);
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    check_idle("post_rst");

    // Contention from pointer 0: grants 0,1,2,3, six cycles apart.
    request(0, 4'b0011);
    request(1, 4'b0101);
    request(2, 4'b0110);
    request(3, 4'b0111);
    @(negedge clk);
    check("cont_first_gnt", 32'(gnt), 32'b0001);
    wait_done("cont0", 10, lat);
    check("cont0_lat", 32'(lat), 32'd4);
    expect_done("cont0");
    for (int k = 1; k < 4; k++) begin
      wait_done("cont", 12, lat);
      check("cont_gap", 32'(lat), 32'd6);
      expect_done("cont");
    end
    @(negedge clk);
    check_idle("cont_end");

    // Single request: latency counted from the driving negedge.
    request(0, 4'b0001);
    @(negedge clk);
    check("single_gnt",  32'(gnt),  32'b0001);
    check("single_busy", 32'(busy), 32'd1);
    wait_done("single", 10, lat);
    check("single_lat", 32'(lat + 1), 32'd5);
    expect_done("single");
    @(negedge clk);
    check_idle("single_end");
    check("single_hold_id",   32'(done_id),  32'd0);
    check("single_hold_comp", 32'(comp_reg), 32'b1111);

    // Zero operand.
    request(2, 4'b0000);
    wait_done("zero", 10, lat);
    expect_done("zero");
    @(negedge clk);

    // Most-negative operand.
    request(1, 4'b1000);
    wait_done("ovf", 10, lat);
    expect_done("ovf");
    @(negedge clk);
    check_idle("ovf_end");

    // Rotating priority: pointer sits at 2, so 3 wins ahead of 1.
    request(1, 4'b1011);
    request(3, 4'b1110);
    sb.delete();
    sb.push_back(model(3, 4'b1110));
    sb.push_back(model(1, 4'b1011));
    wait_done("rr0", 10, lat);
    expect_done("rr0");
    wait_done("rr1", 12, lat);
    check("rr_gap", 32'(lat), 32'd6);
    expect_done("rr1");
    @(negedge clk);

    // Abort: reset during the second SHIFT cycle of requester 3.
    num[3*W +: W] = 4'b0101;
    req[3]        = 1'b1;
    @(negedge clk);
    check("abort_gnt", 32'(gnt), 32'b1000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("abort");
    check("abort_comp",  32'(comp_reg), 32'd0);
    check("abort_carry", 32'(carry),    32'd0);
    check("abort_id",    32'(done_id),  32'd0);
    check("abort_ovf",   32'(ovf),      32'd0);
    @(negedge clk);
    check("abort_nodone", 32'(done), 32'd0);
    rst = 1'b1;
    sb.push_back(model(3, 4'b0101));
    @(negedge clk);
    check("regrant_gnt", 32'(gnt), 32'b1000);
    wait_done("regrant", 10, lat);
    check("regrant_lat", 32'(lat + 1), 32'd5);
    expect_done("regrant");
    @(negedge clk);
    check_idle("final");
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_comp_sched.md
# serial_comp_sched

Round-robin scheduler that shares one bit-serial two's-complement engine among NREQ requesters. It arbitrates pending requests and latches the winner's operand. It sequences the LSB-first serial complement over WIDTH clock cycles, then returns the result with a one-cycle done pulse tagged by requester id. It sits between multiple producer blocks and the serial complement datapath and replaces per-requester complementers.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- NREQ, 4, number of requesters (≥2)
- IDW, $clog2(NREQ), width of requester id (derived, not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- req  in  NREQ  request per requester; held high until own done
- num  in  NREQ*WIDTH  operands; requester i at bits [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant; high from grant edge through done cycle
- busy  out  1  high while the engine is in SHIFT or DONE
- done  out  1  one-cycle pulse; result valid
- done_id  out  IDW  index of requester served; valid with done, held after
- comp_reg  out  WIDTH  two's complement of latched operand; updates only on done
- carry  out  1  final add-one carry; 1 iff operand == 0
- ovf  out  1  operand was the most-negative value (see Configuration)

## Operation
- States: IDLE, SHIFT, DONE. Reset state IDLE.
- IDLE: if any req bit is high, rr_arbiter picks a winner. On that edge: gnt <= onehot(winner), latch num slice into sreg, cnt <= 0, seen <= 0, go to SHIFT. If no req bit is high, stay in IDLE.
- SHIFT, each edge: b = sreg[0]; out bit = seen ? ~b : b; seen <= seen | b; result shifts in from MSB; sreg shifts right; cnt++.
- On the edge where cnt == WIDTH-1: comp_reg <= final result, carry <= ~(seen|b), done_id <= winner, go to DONE.
- DONE, one cycle: done=1, gnt still asserted. Next edge: gnt <= 0, go to IDLE.
- Round robin: after granting i, priority order is i+1, i+2, … mod NREQ. After reset, requester 0 has highest priority.
- The arbiter ignores req changes during SHIFT/DONE. num is sampled only at the grant edge.
- A requester that keeps req high after its done cycle is a new request and is re-arbitrated normally.
- Arithmetic is modulo 2^WIDTH; no width extension.

## Timing
- Reset values (rst low at an edge): gnt=0, busy=0, done=0, done_id=0, comp_reg=0, carry=0, ovf=0, cnt=0, pointer=0, state IDLE.
- Reset mid-operation aborts the operation: no done is produced. After reset is released, a still-pending req is re-granted from pointer 0.
- Latency: req sampled at edge k → done high in the cycle after edge k+WIDTH (WIDTH+1 edges).
- Throughput: one operation per WIDTH+2 cycles. The earliest next grant is edge k+WIDTH+2.
- Simultaneous requests are served strictly in round-robin order, one at a time.
- Only one gnt bit is ever high. busy = (state != IDLE).

## Configuration
- SERIAL_COMP_OVF_EN defined: ovf is registered with comp_reg. ovf = 1 iff the operand == {1'b1, {WIDTH-1{1'b0}}}, i.e. result equals the nonzero input. ovf is held until the next done.
- Undefined: ovf is tied to 0 and no detection logic is built. The port remains in both cases.

## Structure
- Package serial_comp_pkg:
  - state enum (IDLE, SHIFT, DONE)
  - default WIDTH/NREQ localparams
  - function onehot(idx)
- Sub-module rr_arbiter: combinational winner/valid from req and the rotating pointer. The pointer register is updated on grant inside the sub-module.
- Serial datapath (sreg, seen, cnt, result shift register) lives inline in serial_comp_sched.

## Test plan
- Reset: rst=0 for 3 cycles with req=4'b1111 → gnt=0, done=0, comp_reg=0000, carry=0 throughout.
- Single request: req0, num=0001 → gnt=0001 on the next edge; done 5 edges after sampling with comp_reg=1111, carry=0, done_id=0.
- Zero operand: req2, num=0000 → comp_reg=0000, carry=1, done_id=2.
- Contention: req=1111 with nums 0011/0101/0110/0111 → grants in order 0,1,2,3; results 1101, 1011, 1010, 1001; done pulses 6 cycles apart.
- Overflow: req1, num=1000 → comp_reg=1000; ovf=1 with SERIAL_COMP_OVF_EN, ovf=0 without.
- Abort: rst low on the 2nd SHIFT cycle of req3 → all outputs 0 at the next edge, no done. After release with req3 still high, it is re-granted (pointer=0, no lower req) and completes correctly.
